// File: rtl/deserializer_using_demux.sv
// rtl/deserializer_using_demux.sv - LSB-first serial-to-parallel deserializer with counter-driven demux and valid/ready output register
module deserializer_using_demux #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             serial_valid,
    input  logic             serial_data,
    input  logic             serial_flush,
    output logic             parallel_valid,
    output logic [WIDTH-1:0] parallel_data,
    input  logic             parallel_ready,
    output logic             overflow
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] part;
    logic [WIDTH-1:0] we;
    logic [WIDTH-1:0] word;
    logic             accept_bit;
    logic             complete;
    logic             transfer;

    assign accept_bit = serial_valid && !serial_flush;
    assign complete   = accept_bit && (cnt == LAST);
    assign transfer   = parallel_valid && parallel_ready;

    // Demux: decode the bit counter into a one-hot slot write enable and
    // merge the incoming bit into the partial word so the completed word
    // is available in the same cycle as its last bit.
    always_comb begin
        we   = '0;
        word = part;
        if (accept_bit) begin
            we[cnt] = 1'b1;
        end
        for (int i = 0; i < WIDTH; i++) begin
            if (we[i]) begin
                word[i] = serial_data;
            end
        end
    end

    // Bit counter and partial-word slots; flush restarts the word and
    // drops whatever bit is presented alongside it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt  <= '0;
            part <= '0;
        end else if (serial_flush) begin
            cnt <= '0;
        end else if (serial_valid) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (we[i]) begin
                    part[i] <= serial_data;
                end
            end
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

    // Single-entry output register: load on completion when empty or
    // draining this edge, otherwise drop the word and flag overflow.
    always_ff @(posedge clk) begin
        if (!rst) begin
            parallel_valid <= 1'b0;
            parallel_data  <= '0;
            overflow       <= 1'b0;
        end else if (complete) begin
            if (!parallel_valid || parallel_ready) begin
                parallel_data  <= word;
                parallel_valid <= 1'b1;
            end else begin
                overflow <= 1'b1;
            end
        end else if (transfer) begin
            parallel_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_deserializer_using_demux.sv
// tb/tb_deserializer_using_demux.sv - scoreboard testbench for deserializer_using_demux
module tb_deserializer_using_demux;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             serial_valid;
    logic             serial_data;
    logic             serial_flush;
    logic             parallel_valid;
    logic [WIDTH-1:0] parallel_data;
    logic             parallel_ready;
    logic             overflow;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int valid_cycles;

    logic [WIDTH-1:0] expq[$];

    deserializer_using_demux #(.WIDTH(WIDTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .serial_valid   (serial_valid),
        .serial_data    (serial_data),
        .serial_flush   (serial_flush),
        .parallel_valid (parallel_valid),
        .parallel_data  (parallel_data),
        .parallel_ready (parallel_ready),
        .overflow       (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every transfer pops the scoreboard and compares.
    always @(negedge clk) begin
        if (rst && parallel_valid && parallel_ready) begin
            if (expq.size() == 0) begin
                chk("unexpected_word", {24'h0, parallel_data}, 32'hdead_beef);
            end else begin
                chk("word", {24'h0, parallel_data}, {24'h0, expq.pop_front()});
            end
        end
        if (rst && parallel_valid) valid_cycles++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Send a word LSB first; ngap idle cycles are inserted after bit gap_after.
    task automatic send_word(input logic [WIDTH-1:0] w, input int gap_after, input int ngap);
        for (int i = 0; i < WIDTH; i++) begin
            serial_valid = 1'b1;
            serial_data  = w[i];
            tick();
            if (i == gap_after) begin
                serial_valid = 1'b0;
                for (int g = 0; g < ngap; g++) tick();
            end
        end
        serial_valid = 1'b0;
        serial_data  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    initial begin
        logic [WIDTH-1:0] w;
        rst            = 1'b0;
        serial_valid   = 1'b0;
        serial_data    = 1'b0;
        serial_flush   = 1'b0;
        parallel_ready = 1'b0;
        valid_cycles   = 0;
        tick();
        tick();
        rst = 1'b1;
        chk("reset_valid", {31'h0, parallel_valid}, 32'h0);
        chk("reset_data", {24'h0, parallel_data}, 32'h0);
        chk("reset_overflow", {31'h0, overflow}, 32'h0);

        // Test 1: bits 1,0,1,1,0,0,1,0 -> 8'h4D, valid for one cycle
        parallel_ready = 1'b1;
        expq.push_back(8'h4D);
        valid_cycles = 0;
        send_word(8'h4D, -1, 0);
        chk("t1_valid_latency", {31'h0, parallel_valid}, 32'h1);
        tick();
        chk("t1_valid_drop", {31'h0, parallel_valid}, 32'h0);
        chk("t1_valid_cycles", valid_cycles, 1);
        chk("t1_overflow", {31'h0, overflow}, 32'h0);

        // Test 2: 3-cycle gap between bits 2 and 3
        expq.push_back(8'h4D);
        send_word(8'h4D, 2, 3);
        chk("t2_valid_latency", {31'h0, parallel_valid}, 32'h1);
        tick();

        // Test 3: A5 held, 3C dropped, overflow set
        parallel_ready = 1'b0;
        expq.push_back(8'hA5);
        send_word(8'hA5, -1, 0);
        send_word(8'h3C, -1, 0);
        chk("t3_held_data", {24'h0, parallel_data}, 32'hA5);
        chk("t3_held_valid", {31'h0, parallel_valid}, 32'h1);
        chk("t3_overflow", {31'h0, overflow}, 32'h1);
        parallel_ready = 1'b1;
        tick();
        chk("t3_valid_after_xfer", {31'h0, parallel_valid}, 32'h0);
        chk("t3_overflow_sticky", {31'h0, overflow}, 32'h1);
        do_reset();
        chk("t3_reset_overflow", {31'h0, overflow}, 32'h0);

        // Test 4: FF held, ready rises on the edge 01 completes
        parallel_ready = 1'b0;
        expq.push_back(8'hFF);
        expq.push_back(8'h01);
        send_word(8'hFF, -1, 0);
        w = 8'h01;
        for (int i = 0; i < WIDTH; i++) begin
            serial_valid = 1'b1;
            serial_data  = w[i];
            if (i == WIDTH - 1) parallel_ready = 1'b1;
            tick();
        end
        serial_valid = 1'b0;
        chk("t4_valid_stays", {31'h0, parallel_valid}, 32'h1);
        chk("t4_data_loaded", {24'h0, parallel_data}, 32'h01);
        chk("t4_overflow", {31'h0, overflow}, 32'h0);
        tick();

        // Test 5: 5 bits then flush with a valid bit, then 81
        w = 8'hFF;
        for (int i = 0; i < 5; i++) begin
            serial_valid = 1'b1;
            serial_data  = w[i];
            tick();
        end
        serial_flush = 1'b1;
        serial_data  = 1'b1;
        tick();
        serial_flush = 1'b0;
        serial_valid = 1'b0;
        expq.push_back(8'h81);
        send_word(8'h81, -1, 0);
        chk("t5_valid", {31'h0, parallel_valid}, 32'h1);
        tick();
        chk("t5_overflow", {31'h0, overflow}, 32'h0);

        // Test 6: reset mid-word with a held word, then C3
        parallel_ready = 1'b0;
        send_word(8'h5A, -1, 0);
        chk("t6_held_data", {24'h0, parallel_data}, 32'h5A);
        w = 8'hC3;
        for (int i = 0; i < 3; i++) begin
            serial_valid = 1'b1;
            serial_data  = w[i];
            tick();
        end
        serial_valid = 1'b0;
        do_reset();
        chk("t6_reset_valid", {31'h0, parallel_valid}, 32'h0);
        chk("t6_reset_data", {24'h0, parallel_data}, 32'h0);
        chk("t6_reset_overflow", {31'h0, overflow}, 32'h0);
        parallel_ready = 1'b1;
        expq.push_back(8'hC3);
        send_word(8'hC3, -1, 0);
        chk("t6_valid", {31'h0, parallel_valid}, 32'h1);
        tick();
        tick();
        chk("scoreboard_empty", expq.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/deserializer_using_demux.md
# deserializer_using_demux

Sequential counterpart of the mux-based serializing logic: receives a 1-bit serial stream (LSB first) and steers each bit through a counter-driven demultiplexer into its slot of a WIDTH-bit word. A completed word is presented on a valid/ready parallel output held in a single output register. The block sits at the receiving end of a serial link, between the line-side bit source and word-oriented consumer logic.

## Interface

- WIDTH, 8, parallel word width in bits; legal range WIDTH >= 2.
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset; synchronous, active-low; sampled on rising edge of clk.
- serial_valid  input  1  serial_data carries a valid bit this cycle.
- serial_data  input  1  serial bit; first bit of a word is bit 0 (LSB).
- serial_flush  input  1  discard the partially assembled word.
- parallel_valid  output  1  parallel_data holds a complete word.
- parallel_data  output  WIDTH  assembled word.
- parallel_ready  input  1  consumer accepts parallel_data this cycle.
- overflow  output  1  sticky: a completed word was dropped.

## Operation

- Bit counter cnt, $clog2(WIDTH) bits, range 0..WIDTH-1; partial-word register part[WIDTH-1:0].
- Demux: cnt decoded to a one-hot write enable; on a cycle with serial_valid=1 and serial_flush=0, part[cnt] <= serial_data, cnt <= cnt+1.
- Word completion: serial_valid=1, serial_flush=0, cnt=WIDTH-1. Completed word = part[WIDTH-2:0] with serial_data in bit WIDTH-1. cnt wraps to 0; part need not be cleared (every slot is overwritten before next completion).
- Output register: transfer occurs on an edge where parallel_valid=1 and parallel_ready=1.
  - Completion with output empty, or with transfer on the same edge: load completed word, parallel_valid <= 1.
  - Completion while parallel_valid=1 and parallel_ready=0: completed word dropped, output register unchanged, overflow <= 1.
  - Transfer without completion: parallel_valid <= 0; parallel_data keeps last value.
  - While parallel_valid=1 and parallel_ready=0, parallel_data and parallel_valid are stable.
- serial_flush=1: cnt <= 0; any bit presented that cycle is discarded (flush wins over serial_valid). Output register and overflow unaffected; an ongoing transfer still completes.
- serial_valid=0 cycles (gaps) anywhere inside a word: no state change in cnt/part.
- overflow cleared only by reset.

## Timing

- Reset (rst=0 at an edge): cnt=0, part=0, parallel_valid=0, parallel_data=0, overflow=0. Reset mid-word discards the partial word; reset with a held word discards it.
- Latency: parallel_valid rises in the cycle after the edge that captured the last bit (1 cycle from last serial bit to word visible).
- Throughput: one word per WIDTH valid serial cycles, sustained with no bubbles when parallel_ready=1 or when the consumer accepts within WIDTH-1 cycles of parallel_valid rising.
- parallel_ready is a pure input; no combinational path from any input to any output.
- overflow rises in the cycle after the dropping edge.

## Test plan

- Reset then WIDTH=8, serial bits 1,0,1,1,0,0,1,0 (LSB first) on consecutive cycles, parallel_ready=1 -> parallel_valid high for exactly one cycle, one cycle after bit 7, parallel_data=8'h4D, overflow=0.
- Same word with serial_valid deasserted for 3 random cycles between bits 2 and 3 -> parallel_data=8'h4D, valid one cycle after last valid bit.
- Back-to-back words 8'hA5 then 8'h3C, parallel_ready held 0 until after second word completes -> parallel_data stays 8'hA5, overflow=1 after second word's last bit; raising ready -> 8'hA5 transferred once, parallel_valid=0 next cycle.
- Back-to-back words 8'hFF, 8'h01 with parallel_ready asserted exactly on the edge the second word completes -> 8'hFF transferred, 8'h01 loaded same edge, parallel_valid stays 1, overflow=0.
- Send 5 bits, assert serial_flush together with serial_valid=1 for one cycle, then send 8'h81 -> output 8'h81 only; no word from the flushed bits.
- Hold word 8'h5A unaccepted, pulse rst=0 for one cycle mid next word -> parallel_valid=0, parallel_data=0, overflow=0; following full word 8'hC3 delivered correctly.
